sonar_sweep_controller: RTL and testbench

SONAR_SWEEP_CONTROLLER -- requirements
Module: sonar_sweep_controller

---
 rtl/sonar_sweep_controller.sv | 126 ++++++++++++
 tb/tb_sonar_sweep_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sonar_sweep_controller.sv
// sonar_sweep_controller: steps a beam through signed angles, fires a burst per ping and reports the first echo above threshold.
// Define SWEEP_PEAK_TRACK_EN to report the strongest qualifying echo instead of the first one.
module sonar_sweep_controller #(
    parameter int PERIOD_CYCLES = 16777216,
    parameter int BURST_CYCLES  = 524288,
    parameter int BLANK_CYCLES  = 65536,
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10,
    parameter int MAG_WIDTH     = 16,
    localparam int TOF_WIDTH    = $clog2(PERIOD_CYCLES)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic                          continuous_in,
    input  logic [MAG_WIDTH-1:0]          threshold_in,
    input  logic [MAG_WIDTH-1:0]          sample_in,
    input  logic                          sample_valid_in,
    output logic signed [ANGLE_WIDTH-1:0] angle_out,
    output logic                          burst_out,
    output logic                          ping_start_out,
    output logic                          listening_out,
    output logic                          busy_out,
    output logic                          result_valid_out,
    output logic                          result_hit_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [TOF_WIDTH-1:0]          result_tof_out,
    output logic [MAG_WIDTH-1:0]          result_mag_out,
    output logic                          sweep_done_out
);
    typedef enum logic [1:0] {IDLE, BURST, LISTEN, REPORT} state_t;
    localparam logic [TOF_WIDTH-1:0] BURST_LAST  = TOF_WIDTH'(BURST_CYCLES - 1);
    localparam logic [TOF_WIDTH-1:0] PERIOD_LAST = TOF_WIDTH'(PERIOD_CYCLES - 1);
    localparam logic [TOF_WIDTH-1:0] BLANK_C     = TOF_WIDTH'(BLANK_CYCLES);
    localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

    state_t state_q, state_d;
    logic [TOF_WIDTH-1:0] cnt_q, cnt_d, tof_q, tof_d, res_tof_q, res_tof_d;
    logic [MAG_WIDTH-1:0] mag_q, mag_d, res_mag_q, res_mag_d;
    logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d, res_angle_q, res_angle_d;
    logic hit_q, hit_d, res_hit_q, res_hit_d, qualify, take;

    assign ping_start_out   = (state_q == BURST) && (cnt_q == '0);
    assign burst_out        = state_q == BURST;
    assign listening_out    = state_q == LISTEN;
    assign busy_out         = state_q != IDLE;
    assign result_valid_out = state_q == REPORT;
    assign sweep_done_out   = (state_q == REPORT) && (angle_q >= A_MAX);
    assign angle_out        = angle_q;
    assign result_hit_out   = res_hit_q;
    assign result_angle_out = res_angle_q;
    assign result_tof_out   = res_tof_q;
    assign result_mag_out   = res_mag_q;

    assign qualify = listening_out && sample_valid_in && (cnt_q >= BLANK_C) && (sample_in > threshold_in);
`ifdef SWEEP_PEAK_TRACK_EN
    assign take = qualify && (!hit_q || sample_in > mag_q);
`else
    assign take = qualify && !hit_q;
`endif

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        hit_d       = ping_start_out ? 1'b0 : hit_q;
        tof_d       = ping_start_out ? '0 : tof_q;
        mag_d       = ping_start_out ? '0 : mag_q;
        res_hit_d   = res_hit_q;
        res_tof_d   = res_tof_q;
        res_mag_d   = res_mag_q;
        res_angle_d = res_angle_q;
        cnt_d       = (burst_out || (listening_out && cnt_q != PERIOD_LAST)) ? cnt_q + 1'b1 : '0;
        if (take) begin
            hit_d = 1'b1;
            tof_d = cnt_q;
            mag_d = sample_in;
        end
        case (state_q)
            IDLE:   state_d = start_in ? BURST : IDLE;
            BURST:  state_d = (cnt_q == BURST_LAST) ? LISTEN : BURST;
            LISTEN: begin
                if (cnt_q == PERIOD_LAST) begin
                    state_d     = REPORT;
                    res_hit_d   = hit_d;
                    res_tof_d   = tof_d;
                    res_mag_d   = mag_d;
                    res_angle_d = angle_q;
                end
            end
            REPORT: begin
                angle_d = (angle_q < A_MAX) ? angle_q + A_STEP : A_MIN;
                state_d = (angle_q < A_MAX || continuous_in) ? BURST : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            angle_q     <= A_MIN;
            hit_q       <= 1'b0;
            tof_q       <= '0;
            mag_q       <= '0;
            res_hit_q   <= 1'b0;
            res_tof_q   <= '0;
            res_mag_q   <= '0;
            res_angle_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            angle_q     <= angle_d;
            hit_q       <= hit_d;
            tof_q       <= tof_d;
            mag_q       <= mag_d;
            res_hit_q   <= res_hit_d;
            res_tof_q   <= res_tof_d;
            res_mag_q   <= res_mag_d;
            res_angle_q <= res_angle_d;
        end
    end
endmodule

// File: tb/tb_sonar_sweep_controller.sv
// tb_sonar_sweep_controller: directed sweep scenarios with a result scoreboard for sonar_sweep_controller.
module tb_sonar_sweep_controller;
    localparam int PER = 64, BUR = 8, BLK = 12, TW = 6, MW = 16, AW = 8;

    logic clk = 1'b0;
    logic rst, start, cont, sval;
    logic [MW-1:0] thr, samp;
    logic signed [AW-1:0] angle, r_angle;
    logic burst, pstart, listen, busy, r_valid, r_hit, done;
    logic [TW-1:0] r_tof;
    logic [MW-1:0] r_mag;
    int checks = 0, errors = 0;

    typedef struct {int ang; int hit; int tof; int mag;} exp_t;
    exp_t sb[$];
    exp_t last;

    sonar_sweep_controller #(
        .PERIOD_CYCLES(PER), .BURST_CYCLES(BUR), .BLANK_CYCLES(BLK), .ANGLE_WIDTH(AW),
        .ANGLE_MIN(-10), .ANGLE_MAX(10), .ANGLE_STEP(10), .MAG_WIDTH(MW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
        .threshold_in(thr), .sample_in(samp), .sample_valid_in(sval),
        .angle_out(angle), .burst_out(burst), .ping_start_out(pstart),
        .listening_out(listen), .busy_out(busy), .result_valid_out(r_valid),
        .result_hit_out(r_hit), .result_angle_out(r_angle), .result_tof_out(r_tof),
        .result_mag_out(r_mag), .sweep_done_out(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (r_valid) begin
            if (sb.size() == 0) chk("unexpected_result_valid", r_valid, 0);
            else begin
                e = sb.pop_front();
                last = e;
                chk("result_angle", r_angle, e.ang);
                chk("result_hit", r_hit, e.hit);
                chk("result_tof", r_tof, e.tof);
                chk("result_mag", r_mag, e.mag);
            end
        end
    endtask

    function automatic exp_t model(input int ang, input int th, input int ca, va, cb, vb, cc, vc);
        exp_t e;
        int cs[3];
        int vs[3];
        e = '{ang, 0, 0, 0};
        cs = '{ca, cb, cc};
        vs = '{va, vb, vc};
        for (int i = 0; i < 3; i++)
            if (cs[i] >= BUR && cs[i] >= BLK && cs[i] < PER && vs[i] > th)
`ifdef SWEEP_PEAK_TRACK_EN
                if (e.hit == 0 || vs[i] > e.mag) e = '{ang, 1, cs[i], vs[i]};
`else
                if (e.hit == 0) e = '{ang, 1, cs[i], vs[i]};
`endif
        return e;
    endfunction

    task automatic drive_sample(input int k, ca, va, cb, vb, cc, vc);
        sval = (k == ca) || (k == cb) || (k == cc);
        samp = MW'(k == ca ? va : k == cb ? vb : k == cc ? vc : 0);
    endtask

    task automatic ping(input int ang, input int dn, input int ca, va, cb, vb, cc, vc);
        chk("ping_start", pstart, 1);
        chk("burst_first", burst, 1);
        chk("angle", angle, ang);
        sb.push_back(model(ang, int'(thr), ca, va, cb, vb, cc, vc));
        for (int k = 0; k < PER; k++) begin
            drive_sample(k, ca, va, cb, vb, cc, vc);
            if (k == 1) chk("ping_start_once", pstart, 0);
            if (k == BUR - 1) chk("burst_last", burst, 1);
            if (k == BUR) begin
                chk("listen_begin", listen, 1);
                chk("burst_end", burst, 0);
            end
            step();
        end
        sval = 1'b0;
        chk("report_valid", r_valid, 1);
        chk("sweep_done", done, dn);
    endtask

    task automatic reset_outputs();
        chk("rst_angle", angle, -10);
        chk("rst_busy", busy, 0);
        chk("rst_burst", burst, 0);
        chk("rst_ping_start", pstart, 0);
        chk("rst_listen", listen, 0);
        chk("rst_valid", r_valid, 0);
        chk("rst_hit", r_hit, 0);
        chk("rst_tof", r_tof, 0);
        chk("rst_mag", r_mag, 0);
        chk("rst_result_angle", r_angle, 0);
        chk("rst_done", done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; cont = 1'b0; sval = 1'b0; thr = 16'd100; samp = '0;
        repeat (3) step();
        reset_outputs();
        rst = 1'b0; start = 1'b0; sval = 1'b1; samp = 16'd999;
        step();
        chk("idle_after_reset", busy, 0);
        sval = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        ping(-10, 0, 3, 500, 20, 150, -1, 0);
        step();
        ping(0, 0, 10, 150, 30, 100, -1, 0);
        step();
        ping(10, 1, 20, 120, 30, 300, 40, 300);
        step();
        chk("idle_after_sweep", busy, 0);
        chk("angle_wrapped", angle, -10);
        repeat (5) step();
        chk("result_tof_hold", r_tof, last.tof);
        chk("result_mag_hold", r_mag, last.mag);
        chk("still_idle", busy, 0);
        cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        ping(-10, 0, 63, 101, -1, 0, -1, 0);
        step();
        ping(0, 0, 11, 500, 12, 101, -1, 0);
        step();
        ping(10, 1, -1, 0, -1, 0, -1, 0);
        step();
        ping(-10, 0, 50, 200, -1, 0, -1, 0);
        step();
        chk("abort_ping_start", pstart, 1);
        chk("abort_angle", angle, 0);
        for (int k = 0; k < 40; k++) begin
            drive_sample(k, 30, 1000, -1, 0, -1, 0);
            step();
        end
        sval = 1'b0;
        rst = 1'b1; start = 1'b1;
        step();
        reset_outputs();
        repeat (2) step();
        start = 1'b0; cont = 1'b0;
        step();
        rst = 1'b0;
        repeat (70) step();
        chk("idle_after_abort", busy, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
